instruction_fetch: RTL

Fetch stage that sits directly upstream of `instructionMemory`: it owns the program counter, drives `readAddress` into the instruction memory, samples the returned `instruction` word, and registers it into the IF/ID pipeline register consumed by the decoder. It supports stall, branch redirect with flush, and end-of-program detection for the 6-word instruction image.

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, addresses instruction memory and
// registers the returned word into the IF/ID pipeline register. Supports
// stall, branch redirect with a one-bubble flush, and end-of-program stop.
module instruction_fetch #(
    parameter int unsigned INSTR_COUNT = 6,
    parameter logic [31:0] END_ADDR    = 32'(4 * INSTR_COUNT)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic [31:0] instruction,
    output logic [31:0] readAddress,
    output logic [31:0] ifIdInstruction,
    output logic [31:0] ifIdPc,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
    output logic        done,
    output logic [31:0] fetchCount
);

    // Architectural state
    logic [31:0] pc_q,        pc_d;
    logic [31:0] if_instr_q,  if_instr_d;
    logic [31:0] if_pc_q,     if_pc_d;
    logic [31:0] if_pc4_q,    if_pc4_d;
    logic        if_valid_q,  if_valid_d;
    logic        done_q,      done_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    // Branch targets are word-aligned by clearing the two low bits.
    assign target_aligned = branchTarget & ~32'd3;
    assign pc_plus4       = pc_q + 32'd4;

    // Next-state selection: branch beats stall, stall beats fetch, fetch
    // only runs while the program has not reached its end.
    always_comb begin
        // NOTE: every target gets a hold default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        pc_d        = pc_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_pc4_d    = if_pc4_q;
        if_valid_d  = if_valid_q;
        done_d      = done_q;
        fetch_cnt_d = fetch_cnt_q;

        if (branchTaken) begin
            pc_d       = target_aligned;
            if_instr_d = 32'd0;
            if_pc_d    = 32'd0;
            if_pc4_d   = 32'd0;
            if_valid_d = 1'b0;
            done_d     = (target_aligned >= END_ADDR);
        end else if (stall) begin
            // Everything holds.
        end else if (!done_q) begin
            if_instr_d  = instruction;
            if_pc_d     = pc_q;
            if_pc4_d    = pc_plus4;
            if_valid_d  = 1'b1;
            pc_d        = pc_plus4;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            done_d      = (pc_plus4 >= END_ADDR);
        end else begin
            // Idle past the end: stop presenting instructions downstream.
            if_valid_d = 1'b0;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q        <= 32'd0;
            if_instr_q  <= 32'd0;
            if_pc_q     <= 32'd0;
            if_pc4_q    <= 32'd0;
            if_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            pc_q        <= pc_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
            done_q      <= done_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // All outputs come straight from flops; no input reaches them combinationally.
    assign readAddress     = pc_q;
    assign ifIdInstruction = if_instr_q;
    assign ifIdPc          = if_pc_q;
    assign ifIdPcPlus4     = if_pc4_q;
    assign ifIdValid       = if_valid_q;
    assign done            = done_q;
    assign fetchCount      = fetch_cnt_q;

endmodule
